// File: rtl/serial_adder_pkg.sv
// Shared state encodings and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int unsigned MAX_WIDTH = 32;

  function automatic int unsigned idx_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder iterated LSB-first over WIDTH bits with start/ready/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned IDX_W = idx_width(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res_sr;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_accept;
  logic               w_last;
  logic               w_sub;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_state == ST_RUN) && (r_idx == IDX_W'(WIDTH - 1));
  assign w_res_next = {w_fa_sum, r_res_sr[WIDTH-1:1]};

  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State and registered status flags, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE) || (w_next == ST_DONE);
      r_busy  <= (w_next == ST_RUN);
      r_done  <= (w_next == ST_DONE);
    end
  end

  // Operand capture, serial iteration and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= w_sub ? ~b : b;
      r_carry <= w_sub ? 1'b1 : cin;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_next;
      r_carry  <= w_fa_cout;
      r_idx    <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_fa_cout;
      end
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8; define SERIAL_ADDER_SUB_EN to also cover subtraction.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Drive one start cycle and record the expected result; returns at the negedge after the accepting edge
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    logic [W:0] e;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    e = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait on negedges until done is seen or the budget runs out
  task automatic wait_done(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL rst_sum: got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b want 0", cout); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL idle_hold: got rdy/busy/done %b want 100", {ready, busy, done}); end
  endtask

  task automatic test_basic();
    int lat; bit to; int busy_cnt; logic [W:0] e;
    start_op(8'h05, 8'h03, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    n_cmp++; if (busy_cnt != 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if ({ready, busy, done} !== 3'b101) begin n_err++; $display("FAIL basic_done_flags: got %b want 101", {ready, busy, done}); end
    wait_done(lat, to);
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL basic_result: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL basic_result: got %h want %h", {cout, sum}, e); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_pulse: done still %b", done); end
    n_cmp++; if (sum !== 8'h08) begin n_err++; $display("FAIL basic_hold: got %h want 08", sum); end
  endtask

  task automatic test_carry();
    int lat; bit to; logic [W:0] e;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(lat, to);
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL carry_latency: got %0d want 8", lat); end
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL carry_wrap: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL carry_wrap: got %h want %h", {cout, sum}, e); end
    end
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(lat, to);
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL carry_cin: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL carry_cin: got %h want %h", {cout, sum}, e); end
    end
  endtask

  task automatic test_ignore_start();
    int lat; bit to; logic [W:0] e;
    start_op(8'h10, 8'h20, 1'b0);
    repeat (4) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ign_ready: got %b want 0", ready); end
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, to);
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL ign_result: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL ign_result: got %h want %h", {cout, sum}, e); end
    end
    @(negedge clk);
    n_cmp++; if ({ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL ign_idle: got %b want 100", {ready, busy, done}); end
    start_op(8'hAA, 8'h55, 1'b0);
    wait_done(lat, to);
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL ign_restart: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL ign_restart: got %h want %h", {cout, sum}, e); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; logic [W:0] e;
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h003);
    @(negedge clk);
    a = 8'h7F; b = 8'h01;
    exp_q.push_back(9'h080);
    wait_done(lat, to);
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL b2b_first: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL b2b_first: got %h want %h", {cout, sum}, e); end
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_bubble: busy %b want 1", busy); end
    wait_done(lat, to);
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL b2b_spacing: got %0d want 8", lat); end
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL b2b_second: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL b2b_second: got %h want %h", {cout, sum}, e); end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to; int done_cnt; logic [W:0] e;
    @(negedge clk);
    a = 8'h33; b = 8'h44; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL abort_flags: got %b want 100", {ready, busy, done}); end
    n_cmp++; if ({cout, sum} !== 9'h000) begin n_err++; $display("FAIL abort_result: got %h want 000", {cout, sum}); end
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (i == 2) rst_n = 1'b1;
    end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
    start_op(8'h0A, 8'h0B, 1'b0);
    wait_done(lat, to);
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL abort_recover: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL abort_recover: got %h want %h", {cout, sum}, e); end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat; bit to; logic [W:0] e;
    @(negedge clk);
    a = 8'h10; b = 8'h03; cin = 1'b0; sub = 1'b1; start = 1'b1;
    exp_q.push_back({1'b0, 8'h10} + {1'b0, ~8'h03} + 9'h001);
    @(negedge clk);
    start = 1'b0; sub = 1'b0;
    wait_done(lat, to);
    n_cmp++;
    if (to || exp_q.size() == 0) begin n_err++; $display("FAIL sub_result: timeout or empty queue"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin n_err++; $display("FAIL sub_result: got %h want %h", {cout, sum}, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d results left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
